s2_sequenciador_jogo: RTL
=========================

Name: s2_sequenciador_jogo

Overview:
- Second-generation control unit for the colour-sequence memory game. It plays back the sequence, waits for player moves, compares them, counts errors and computes the score.
- Unlike the first generation, it integrates its own address, round, timer, error and score counters. It is parametrised in button count, sequence depth and timing, and supports a lives mode.
- Sits between the sequence ROM, button inputs, LED outputs and the score display.

Parameters:
- N_BOTOES, 4: width of one-hot button/LED/ROM data vectors.
- ADDR_W, 4: sequence address width.
- N_RODADAS, 16: rounds to win, 1..2^ADDR_W.
- T_LED, 1000: cycles each sequence LED is lit during playback. The gap after each LED is T_LED/2 cycles, minimum 1.
- T_JOGADA, 5000: cycles allowed per move before timeout.
- VIDAS, 3: errors tolerated in lives mode, 1..7.
- PONTOS_INI, 100: initial score.
- PENALIDADE, 10: score deducted per error.

Ports:
- clock, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- jogar, in, 1: start/restart request.
- modo, in, 2: 00 normal, 01 treino (no timeout), 10 vidas, 11 treated as 00. Sampled in PREPARA only.
- botoes, in, N_BOTOES: player buttons, already synchronised.
- mem_dado, in, N_BOTOES: ROM word at mem_endereco, combinational, valid same cycle.
- mem_endereco, out, ADDR_W: ROM read address.
- leds, out, N_BOTOES: LED drive.
- rodada, out, ADDR_W: current round index, 0-based.
- pontos, out, 8: current score.
- erros, out, 3: errors committed this game.
- pronto, out, 1: game finished.
- ganhou, out, 1: finished by completing N_RODADAS.
- perdeu, out, 1: finished by error or timeout.
- timeout, out, 1: finish cause was a timeout.
- db_estado, out, 5: state code for debug.

Behaviour:
- Reset (reset_n=0): state INICIAL. All counters and outputs are 0, except pontos=PONTOS_INI.
- Move detection: an internal register holds the previous botoes value. A move occurs when botoes!=0 and the previous value was 0. Held buttons generate no further moves.
- INICIAL(0): outputs idle. jogar=1 -> PREPARA.
- PREPARA(1), one cycle:
  - Clear address, rodada, erros and timers.
  - pontos=PONTOS_INI, vidas=VIDAS.
  - Latch modo, then go to MOSTRA.
- MOSTRA(2): leds=mem_dado for exactly T_LED cycles, then APAGA.
- APAGA(3): leds=0 for T_LED/2 cycles.
  - At the end, if address==rodada: address=0, move timer cleared, -> ESPERA.
  - Otherwise address+1 -> MOSTRA.
- Playback latency: leds first shows mem_dado[0] in the second cycle after jogar is sampled.
- ESPERA(4): leds=botoes (echo). Move timer counts, except in treino mode.
  - Move detected -> REGISTRA.
  - Timer reaches T_JOGADA-1 with no move -> FIM_PERDEU with timeout=1.
  - A move and the timer expiry in the same cycle: the move wins.
- REGISTRA(5): capture botoes into the move register, -> COMPARA.
- COMPARA(6): compare the move register with mem_dado. Multi-hot moves never match.
  - Match and address==rodada -> FIM_RODADA.
  - Match, otherwise -> PROXIMO.
  - Mismatch -> ERROU.
- PROXIMO(7): address+1, move timer cleared, -> ESPERA.
- ERROU(8), one cycle: erros+1 (saturating at 7), pontos=max(pontos-PENALIDADE,0).
  - Normal or treino mode -> FIM_PERDEU.
  - Vidas mode: vidas-1. If the result is 0 -> FIM_PERDEU. Otherwise address=0 -> MOSTRA (replay the same round).
- FIM_RODADA(9), one cycle:
  - If rodada==N_RODADAS-1 -> FIM_GANHOU.
  - Otherwise rodada+1, address=0 -> MOSTRA.
- FIM_GANHOU(10): pronto=1, ganhou=1.
- FIM_PERDEU(11): pronto=1, perdeu=1. timeout holds its cause.
- Both end states: leds=0, pontos/erros frozen. jogar=1 -> PREPARA, which clears the flags.
- jogar is ignored in all other states.
- Outputs are Moore, decoded from the state and registered counters. mem_endereco equals the address counter at all times.
- Unused state codes -> INICIAL.
- Asynchronous reset mid-game returns to the reset values immediately.

Decomposition:
- Shared package s2_pkg: state encoding constants, modo codes and score width.
- One natural sub-module, s2_temporizador: a parametrised down-counter with zera/conta/fim, used for the LED and move timers.

Test Plan:
- Win path: N_RODADAS=2, T_LED=4, T_JOGADA=20, ROM=[0001,0100]. Press correctly in both rounds. Required: pronto=ganhou=1, pontos=100, erros=0, rodada=1, db_estado=10.
- Playback timing: jogar pulse. Required: leds=0001 for exactly 4 cycles starting 2 cycles after jogar, then 0 for 2 cycles. ESPERA is entered with mem_endereco=0.
- Timeout: normal mode, no press in ESPERA. Required: 20 cycles later perdeu=timeout=1. In treino mode, the same stimulus must stay in ESPERA for 200 or more cycles.
- Lives: modo=10, VIDAS=3, wrong press (0010) three times. Required: replay after the 1st and 2nd errors with erros=1,2 and pontos=90,80. After the 3rd error: perdeu=1, erros=3, pontos=70.
- Held and multi-hot buttons: hold 0001 across two rounds, which registers one move only. Press 0011, which is an error. Press coinciding with the timer's final cycle must register the move, not a timeout.
- Reset/restart: assert reset_n=0 during MOSTRA. Required: immediate INICIAL, leds=0, pontos=100. jogar in FIM_PERDEU restarts with all flags cleared.

Source files
------------

// File: rtl/s2_pkg.sv
// rtl/s2_pkg.sv - shared state codes, modo codes and counter widths for the game sequencer
package s2_pkg;

  localparam int PONTOS_W = 8;
  localparam int ERROS_W  = 3;
  localparam int ESTADO_W = 5;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL    = 5'd0,
    PREPARA    = 5'd1,
    MOSTRA     = 5'd2,
    APAGA      = 5'd3,
    ESPERA     = 5'd4,
    REGISTRA   = 5'd5,
    COMPARA    = 5'd6,
    PROXIMO    = 5'd7,
    ERROU      = 5'd8,
    FIM_RODADA = 5'd9,
    FIM_GANHOU = 5'd10,
    FIM_PERDEU = 5'd11
  } estado_t;

  typedef enum logic [1:0] {
    MODO_NORMAL    = 2'b00,
    MODO_TREINO    = 2'b01,
    MODO_VIDAS     = 2'b10,
    MODO_RESERVADO = 2'b11
  } modo_t;

endpackage

// File: rtl/s2_sequenciador_jogo_if.sv
// rtl/s2_sequenciador_jogo_if.sv - sequence ROM read port between the sequencer and the ROM
interface s2_sequenciador_jogo_if #(
  parameter int N_BOTOES = 4,
  parameter int ADDR_W   = 4
);

  logic [ADDR_W-1:0]   mem_endereco;
  logic [N_BOTOES-1:0] mem_dado;

  modport master (output mem_endereco, input mem_dado);
  modport slave  (input mem_endereco, output mem_dado);

endinterface

// File: rtl/s2_temporizador.sv
// rtl/s2_temporizador.sv - loadable down-counter; fim is high while the count sits at zero
module s2_temporizador #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               zera,
  input  logic               conta,
  input  logic [LARGURA-1:0] carga,
  output logic               fim
);

  logic [LARGURA-1:0] contagem;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= carga;
    end else if (conta && (contagem != '0)) begin
      contagem <= contagem - 1'b1;
    end
  end

  assign fim = (contagem == '0);

endmodule

// File: rtl/s2_sequenciador_jogo.sv
// rtl/s2_sequenciador_jogo.sv - colour-sequence game control unit: playback, move check, errors, score
module s2_sequenciador_jogo
  import s2_pkg::*;
#(
  parameter int N_BOTOES   = 4,
  parameter int ADDR_W     = 4,
  parameter int N_RODADAS  = 16,
  parameter int T_LED      = 1000,
  parameter int T_JOGADA   = 5000,
  parameter int VIDAS      = 3,
  parameter int PONTOS_INI = 100,
  parameter int PENALIDADE = 10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 jogar,
  input  logic [1:0]           modo,
  input  logic [N_BOTOES-1:0]  botoes,
  s2_sequenciador_jogo_if.master rom,
  output logic [N_BOTOES-1:0]  leds,
  output logic [ADDR_W-1:0]    rodada,
  output logic [PONTOS_W-1:0]  pontos,
  output logic [ERROS_W-1:0]   erros,
  output logic                 pronto,
  output logic                 ganhou,
  output logic                 perdeu,
  output logic                 timeout,
  output logic [ESTADO_W-1:0]  db_estado
);

  localparam int T_APAGA = (T_LED / 2 < 1) ? 1 : T_LED / 2;
  localparam int LED_W   = $clog2(T_LED + 1);
  localparam int JOG_W   = $clog2(T_JOGADA + 1);

  estado_t             estado, estadoProx;
  modo_t               modoReg;
  logic [ADDR_W-1:0]   endereco, rodadaReg;
  logic [PONTOS_W-1:0] pontosReg;
  logic [ERROS_W-1:0]  errosReg;
  logic [2:0]          vidasReg;
  logic [N_BOTOES-1:0] botoesAnt, jogadaReg;
  logic                timeoutReg;

  logic             jogada, acerto, fimEndereco, ultimaRodada, treino;
  logic             ledZera, ledConta, ledFim;
  logic [LED_W-1:0] ledCarga;
  logic             jogZera, jogConta, jogFim;

  // A move is a rising edge of "any button down"; holding keeps it from repeating.
  assign jogada       = (botoes != '0) && (botoesAnt == '0);
  assign acerto       = (jogadaReg == rom.mem_dado) && $onehot(jogadaReg);
  assign fimEndereco  = (endereco == rodadaReg);
  assign ultimaRodada = (rodadaReg == ADDR_W'(N_RODADAS - 1));
  assign treino       = (modoReg == MODO_TREINO);

  // LED timer reloads on every state change, with the gap length when heading to APAGA.
  assign ledZera  = (estadoProx != estado);
  assign ledConta = (estado == MOSTRA) || (estado == APAGA);
  assign ledCarga = (estadoProx == APAGA) ? LED_W'(T_APAGA - 1) : LED_W'(T_LED - 1);

  assign jogZera  = (estado != ESPERA);
  assign jogConta = (estado == ESPERA) && !treino;

  s2_temporizador #(.LARGURA(LED_W)) u_tempLed (
    .clock   (clock),
    .reset_n (reset_n),
    .zera    (ledZera),
    .conta   (ledConta),
    .carga   (ledCarga),
    .fim     (ledFim)
  );

  s2_temporizador #(.LARGURA(JOG_W)) u_tempJogada (
    .clock   (clock),
    .reset_n (reset_n),
    .zera    (jogZera),
    .conta   (jogConta),
    .carga   (JOG_W'(T_JOGADA - 1)),
    .fim     (jogFim)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= INICIAL;
    end else begin
      estado <= estadoProx;
    end
  end

  always_comb begin
    estadoProx = estado;
    case (estado)
      INICIAL:    if (jogar) estadoProx = PREPARA;
      PREPARA:    estadoProx = MOSTRA;
      MOSTRA:     if (ledFim) estadoProx = APAGA;
      APAGA:      if (ledFim) estadoProx = fimEndereco ? ESPERA : MOSTRA;
      ESPERA: begin
        if (jogada) estadoProx = REGISTRA;
        else if (jogFim && !treino) estadoProx = FIM_PERDEU;
      end
      REGISTRA:   estadoProx = COMPARA;
      COMPARA: begin
        if (!acerto) estadoProx = ERROU;
        else if (fimEndereco) estadoProx = FIM_RODADA;
        else estadoProx = PROXIMO;
      end
      PROXIMO:    estadoProx = ESPERA;
      ERROU:      estadoProx = ((modoReg == MODO_VIDAS) && (vidasReg > 3'd1)) ? MOSTRA : FIM_PERDEU;
      FIM_RODADA: estadoProx = ultimaRodada ? FIM_GANHOU : MOSTRA;
      FIM_GANHOU,
      FIM_PERDEU: if (jogar) estadoProx = PREPARA;
      default:    estadoProx = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      endereco   <= '0;
      rodadaReg  <= '0;
      pontosReg  <= PONTOS_W'(PONTOS_INI);
      errosReg   <= '0;
      vidasReg   <= '0;
      modoReg    <= MODO_NORMAL;
      botoesAnt  <= '0;
      jogadaReg  <= '0;
      timeoutReg <= 1'b0;
    end else begin
      botoesAnt <= botoes;
      case (estado)
        PREPARA: begin
          endereco   <= '0;
          rodadaReg  <= '0;
          errosReg   <= '0;
          pontosReg  <= PONTOS_W'(PONTOS_INI);
          vidasReg   <= 3'(VIDAS);
          modoReg    <= (modo == MODO_RESERVADO) ? MODO_NORMAL : modo_t'(modo);
          timeoutReg <= 1'b0;
        end
        APAGA:    if (ledFim) endereco <= fimEndereco ? '0 : endereco + 1'b1;
        ESPERA:   if (estadoProx == FIM_PERDEU) timeoutReg <= 1'b1;
        REGISTRA: jogadaReg <= botoes;
        PROXIMO:  endereco <= endereco + 1'b1;
        ERROU: begin
          errosReg  <= (errosReg == 3'd7) ? errosReg : errosReg + 1'b1;
          pontosReg <= (pontosReg >= PONTOS_W'(PENALIDADE)) ? pontosReg - PONTOS_W'(PENALIDADE) : '0;
          if (modoReg == MODO_VIDAS) begin
            vidasReg <= vidasReg - 1'b1;
            endereco <= '0;
          end
        end
        FIM_RODADA: begin
          if (!ultimaRodada) begin
            rodadaReg <= rodadaReg + 1'b1;
            endereco  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    leds = '0;
    case (estado)
      MOSTRA:  leds = rom.mem_dado;
      ESPERA:  leds = botoes;
      default: leds = '0;
    endcase
  end

  assign rom.mem_endereco = endereco;
  assign rodada           = rodadaReg;
  assign pontos           = pontosReg;
  assign erros            = errosReg;
  assign ganhou           = (estado == FIM_GANHOU);
  assign perdeu           = (estado == FIM_PERDEU);
  assign pronto           = ganhou || perdeu;
  assign timeout          = timeoutReg;
  assign db_estado        = estado;

endmodule
